// File: rtl/jtag_master_pkg.sv
// Shared JTAG master types: command opcodes, TAP states
// and the IEEE 1149.1 TAP transition function.
package jtag_master_pkg;

  typedef enum logic [1:0] {
    OP_RESET   = 2'd0,
    OP_IDLE    = 2'd1,
    OP_IR_SCAN = 2'd2,
    OP_DR_SCAN = 2'd3
  } op_e;

  typedef enum logic [3:0] {
    TAP_EXIT2_DR = 4'h0,
    TAP_EXIT1_DR = 4'h1,
    TAP_SHIFT_DR = 4'h2,
    TAP_PAUSE_DR = 4'h3,
    TAP_SEL_IR   = 4'h4,
    TAP_UPD_DR   = 4'h5,
    TAP_CAP_DR   = 4'h6,
    TAP_SEL_DR   = 4'h7,
    TAP_EXIT2_IR = 4'h8,
    TAP_EXIT1_IR = 4'h9,
    TAP_SHIFT_IR = 4'hA,
    TAP_PAUSE_IR = 4'hB,
    TAP_RTI      = 4'hC,
    TAP_UPD_IR   = 4'hD,
    TAP_CAP_IR   = 4'hE,
    TAP_TLR      = 4'hF
  } tap_e;

  localparam int TLR_TMS_CNT = 5;

  function automatic tap_e tap_next(tap_e s, logic tms);
    tap_e n;
    n = s;
    unique case (s)
      TAP_TLR:      n = tms ? TAP_TLR      : TAP_RTI;
      TAP_RTI:      n = tms ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_DR:   n = tms ? TAP_SEL_IR   : TAP_CAP_DR;
      TAP_CAP_DR:   n = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_SHIFT_DR: n = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_EXIT1_DR: n = tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
      TAP_PAUSE_DR: n = tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
      TAP_EXIT2_DR: n = tms ? TAP_UPD_DR   : TAP_SHIFT_DR;
      TAP_UPD_DR:   n = tms ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_IR:   n = tms ? TAP_TLR      : TAP_CAP_IR;
      TAP_CAP_IR:   n = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_SHIFT_IR: n = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_EXIT1_IR: n = tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
      TAP_PAUSE_IR: n = tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
      TAP_EXIT2_IR: n = tms ? TAP_UPD_IR   : TAP_SHIFT_IR;
      TAP_UPD_IR:   n = tms ? TAP_SEL_DR   : TAP_RTI;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_master_seq_tck_gen.sv
// TCK divider: half-period of div+1 clk cycles, strobes
// fire on the clk edge where tck changes.
module jtag_tck_gen
  import jtag_master_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tck,
  output logic             rise_stb,
  output logic             fall_stb
);

  logic [DIV_W-1:0] cnt;
  logic             wrap;

  assign wrap     = en && (cnt == div);
  assign rise_stb = wrap && !tck;
  assign fall_stb = wrap && tck;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (wrap) begin
      cnt <= '0;
      tck <= ~tck;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/jtag_master_seq.sv
// JTAG master engine: sequences TAP navigation and scans
// from valid/ready commands, mirroring the target TAP state.
module jtag_master_seq
  import jtag_master_pkg::*;
#(
  parameter int MAX_LEN = 128,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int DIV_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DIV_W-1:0]   div,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               rsp_err,
  output logic [3:0]         tap_state,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo,
  output logic               trst_n
);

  localparam int IDX_W = $clog2(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_TRST, S_TLR5, S_PRE,
    S_SHIFT, S_POST, S_RUN, S_DONE
  } st_e;

  st_e                st, nxt;
  logic [LEN_W-1:0]   cnt, last, len_q;
  logic [MAX_LEN-1:0] data_q, cap_q;
  logic [DIV_W-1:0]   div_q;
  logic               ir_q, err_q, synced_q;
  tap_e               tap_q;
  logic               gen_en, gen_tck;
  logic               rise_stb, fall_stb;
  logic               len0, is_scan;
  logic [IDX_W-1:0]   idx;

  assign len0    = (len_q == '0);
  assign is_scan = cmd_op[1];
  assign idx     = cnt[IDX_W-1:0];

  jtag_tck_gen #(.DIV_W(DIV_W)) u_tck (
    .clk      (clk),
    .rst      (rst),
    .en       (gen_en),
    .div      (div_q),
    .tck      (gen_tck),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  always_comb begin
    nxt    = st;
    gen_en = 1'b0;
    last   = '0;
    tms    = 1'b1;
    tdi    = 1'b0;
    unique case (st)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_op == OP_RESET)
            nxt = S_TRST;
          else if (cmd_op == OP_IDLE)
            nxt = (cmd_len == '0) ? S_DONE : S_RUN;
          else
            nxt = synced_q ? S_PRE : S_DONE;
        end
      end
      S_TRST: begin
        gen_en = 1'b1;
        if (fall_stb) nxt = S_TLR5;
      end
      S_TLR5: begin
        gen_en = 1'b1;
        last   = LEN_W'(TLR_TMS_CNT);
        tms    = cnt < last;
        if (fall_stb && cnt == last) nxt = S_DONE;
      end
      S_RUN: begin
        gen_en = 1'b1;
        last   = len_q - 1'b1;
        tms    = 1'b0;
        if (fall_stb && cnt == last) nxt = S_DONE;
      end
      S_PRE: begin
        // zero-length scans stop at Capture and leave via Exit1
        gen_en = 1'b1;
        if (ir_q) last = len0 ? LEN_W'(2) : LEN_W'(3);
        else      last = len0 ? LEN_W'(1) : LEN_W'(2);
        tms = ir_q ? (cnt < LEN_W'(2)) : (cnt == '0);
        if (fall_stb && cnt == last) nxt = S_SHIFT;
      end
      S_SHIFT: begin
        gen_en = 1'b1;
        last   = len0 ? '0 : len_q - 1'b1;
        tms    = (cnt == last);
        tdi    = !len0 && data_q[idx];
        if (fall_stb && cnt == last) nxt = S_POST;
      end
      S_POST: begin
        gen_en = 1'b1;
        last   = LEN_W'(1);
        tms    = (cnt == '0);
        if (fall_stb && cnt == last) nxt = S_DONE;
      end
      S_DONE: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= S_IDLE;
      cnt      <= '0;
      len_q    <= '0;
      data_q   <= '0;
      cap_q    <= '0;
      div_q    <= '0;
      ir_q     <= 1'b0;
      err_q    <= 1'b0;
      synced_q <= 1'b0;
      tap_q    <= TAP_TLR;
    end else begin
      st <= nxt;
      if (fall_stb)
        cnt <= (cnt == last) ? '0 : cnt + 1'b1;
      if (st == S_IDLE && cmd_valid) begin
        div_q  <= div;
        data_q <= cmd_data;
        cap_q  <= '0;
        ir_q   <= (cmd_op == OP_IR_SCAN);
        err_q  <= is_scan && !synced_q;
        if (is_scan && cmd_len > LEN_W'(MAX_LEN))
          len_q <= LEN_W'(MAX_LEN);
        else
          len_q <= cmd_len;
      end
      if (st == S_SHIFT && rise_stb && !len0)
        cap_q[idx] <= tdo;
      if (st == S_TRST) begin
        tap_q    <= TAP_TLR;
        synced_q <= 1'b0;
      end else if (rise_stb) begin
        tap_q <= tap_next(tap_q, tms);
      end
      if (st == S_TLR5 && nxt == S_DONE)
        synced_q <= 1'b1;
    end
  end

  assign cmd_ready = (st == S_IDLE);
  assign rsp_valid = (st == S_DONE);
  assign rsp_err   = (st == S_DONE) && err_q;
  assign rsp_data  = (st == S_DONE) ? cap_q : '0;
  assign tck       = gen_tck && (st != S_TRST);
  assign trst_n    = (st != S_TRST);
  assign tap_state = tap_q;

endmodule

// File: doc/jtag_master_seq.md
Name: jtag_master_seq

Overview:
Synthesizable, parameterised JTAG master engine that replaces hand-sequenced TCK/TMS bit-banging in benches and on-chip debug bridges. It accepts scan commands over a valid/ready interface and generates TCK from the system clock with a programmable divider. It drives the TAP navigation for RESET, IDLE, IR-scan and DR-scan of arbitrary length up to MAX_LEN, and returns the captured TDO bits. It tracks the target TAP state and rejects scans until the TAP is known-synced.

Parameters:
MAX_LEN, 128, maximum scan length in bits (IR or DR).
LEN_W, $clog2(MAX_LEN+1), width of the length field.
DIV_W, 8, width of the TCK divider field.

Ports:
clk  in  1  system clock; single clock domain.
rst  in  1  reset, synchronous, active-high.
div  in  DIV_W  TCK half-period minus 1, in clk cycles; sampled at command accept.
cmd_valid  in  1  command valid.
cmd_ready  out  1  engine idle, command accepted when valid&ready.
cmd_op  in  2  0=RESET, 1=IDLE, 2=IR_SCAN, 3=DR_SCAN.
cmd_len  in  LEN_W  bits to shift (scans) or TCK count (IDLE).
cmd_data  in  MAX_LEN  TDI data, LSB shifted first.
rsp_valid  out  1  one-cycle completion pulse.
rsp_data  out  MAX_LEN  captured TDO, bit i = i-th shifted bit, unused bits 0.
rsp_err  out  1  qualifies rsp_valid; scan rejected (TAP not synced).
tap_state  out  4  mirrored IEEE 1149.1 TAP state.
tck  out  1  test clock.
tms  out  1  test mode select.
tdi  out  1  test data in.
tdo  in  1  test data out.
trst_n  out  1  TAP reset, active-low.

Behaviour:
- Reset values: tck=0, tms=1, tdi=0, trst_n=1, cmd_ready=1, rsp_valid=0, rsp_err=0, rsp_data=0, tap_state=TLR, synced=0.
- TCK period is 2*(div+1) clk cycles.
- Each TCK cycle: tms/tdi update on the falling edge (start of the low phase); tdo is sampled on the rising edge.
- FSM states: IDLE, TRST, TLR5, PRE, SHIFT, POST, RUN, DONE.
- RESET: trst_n low for one TCK period with tck held 0. Then 5 TCKs with TMS=1, then 1 TCK with TMS=0. Ends in RTI; sets synced=1.
- IDLE: cmd_len TCKs with TMS=0, staying in RTI. cmd_len=0 completes with no TCK.
- IR_SCAN: starts in RTI. PRE TMS sequence 1,1,0,0 reaches Shift-IR. SHIFT runs cmd_len TCKs; the last bit uses TMS=1 (Exit1). POST TMS sequence 1,0 goes Update then RTI.
- DR_SCAN: same as IR_SCAN with PRE TMS sequence 1,0,0.
- Scan with cmd_len=0: from Capture, TMS=1 goes directly to Exit1; rsp_data=0.
- Scan with cmd_len>MAX_LEN: length clamped to MAX_LEN.
- Scan while synced=0: no TCK edges; rsp_valid with rsp_err=1 on the cycle after accept.
- DONE: rsp_valid pulses for one cycle with data. RESET/IDLE responses return data 0. cmd_ready reasserts the following cycle. No back-pressure on rsp.
- cmd_ready is high only in IDLE. A command is never accepted in the rsp_valid cycle.
- tap_state updates on every TCK rise per the standard TAP table.
- rst mid-operation: all outputs return to reset values on the next clk; no rsp_valid is issued; synced=0.

Decomposition:
- jtag_master_pkg holds: op enum; 16-entry TAP state enum; next-state function tap_next(state, tms); TLR_TMS_CNT=5 constant.
- Sub-module jtag_tck_gen: divider counter producing tck plus one-clk rise_stb and fall_stb strobes. It has an enable input; disabling it forces tck=0.

Test Plan:
1. rst, then RESET with div=1: trst_n low for 4 clk; 5 TCKs with tms=1, then 1 with tms=0; TCK period 4 clk; rsp_valid with data 0; tap_state=RTI.
2. IR_SCAN len=4, data=4'b0001, TAP model with IR capture 4'b0101: TMS sequence over 10 TCKs is 1,1,0,0,0,0,0,1,1,0; model IR=0001; rsp_data=4'b0101.
3. DR_SCAN len=32, model IDCODE 32'h1BAD_C0DE: exactly 32 Shift-DR TCKs; rsp_data=32'h1BAD_C0DE.
4. DR_SCAN len=67 through a 1-bit model bypass register (reset 0): rsp_data[66:0]={cmd_data[65:0],1'b0}; len=0 gives TMS sequence 1,0,1,1,0 and rsp_data=0.
5. DR_SCAN immediately after rst with no RESET: rsp_err=1 one cycle after accept; tck shows no edges.
6. rst asserted mid-way through the DR_SCAN shift phase: next clk tck=0, tms=1, cmd_ready=1; no rsp_valid; next scan rejected until RESET completes.
